// File: rtl/ame_equation_builder_if.sv
// Sample stream into the AME equation builder:
// gradient vector, residual, last marker and model flag.
interface ame_equation_builder_if #(
   parameter int COEF_BITS = 16
);
   logic                      samp_valid;
   logic                      samp_ready;
   logic                      samp_last;
   logic [5:0][COEF_BITS-1:0] samp_coef;
   logic [COEF_BITS-1:0]      samp_resid;
   logic                      affine_param6;

   modport master (
      output samp_valid,
      output samp_last,
      output samp_coef,
      output samp_resid,
      output affine_param6,
      input  samp_ready
   );

   modport slave (
      input  samp_valid,
      input  samp_last,
      input  samp_coef,
      input  samp_resid,
      input  affine_param6,
      output samp_ready
   );
endinterface

// File: rtl/ame_equation_builder.sv
// AME normal-equation builder: A=sum(c*c'), B=sum(c*b), issued to the solver.
// Define AME_EQUATION_BUILDER_SATURATE_EN for sticky clamp-on-overflow accumulation.
module ame_equation_builder #(
   parameter int COEF_BITS      = 16,
   parameter int COMP_DATA_BITS = 64,
   parameter int SAMP_CNT_BITS  = 12
) (
   input  logic                                clk_i,
   input  logic                                rst_n_i,
   ame_equation_builder_if.slave               samp,
   output logic                                comp_init_o,
   input  logic                                comp_done_i,
   output logic [5:0][6:0][COMP_DATA_BITS-1:0] comp_data_o,
   output logic                                affine_param6_o,
   output logic [SAMP_CNT_BITS-1:0]            samp_count_o
);
   localparam int PW = 2 * COEF_BITS;
   localparam int W  = COMP_DATA_BITS;

   typedef enum logic [2:0] {
      IDLE,
      ACCUM,
      ROW,
      ISSUE,
      WAIT
   } state_e;

   state_e                              state_q;
   state_e                              state_d;
   logic [6:0][COEF_BITS-1:0]           opnd_q;
   logic [2:0]                          row_q;
   logic                                last_q;
   logic [5:0][6:0][W-1:0]              mat_q;
   logic [6:0][W-1:0]                   row_d;
   logic                                accept;
   logic                                clr;
   logic                                model6;
   logic signed [PW-1:0]                mul_a [7];
   logic signed [PW-1:0]                mul_b [7];
   logic signed [PW-1:0]                prod  [7];
   logic signed [W-1:0]                 addend[7];
   logic signed [W-1:0]                 acc   [7];
   logic signed [W-1:0]                 sum   [7];
`ifdef AME_EQUATION_BUILDER_SATURATE_EN
   logic [5:0][6:0]                     sat_q;
   logic [6:0]                          ovf;
`endif

   assign accept      = samp.samp_valid & samp.samp_ready;
   assign clr         = (state_q == IDLE) |
                        ((state_q == WAIT) & comp_done_i);
   // model flag comes from the bus only on the first sample of a block
   assign model6      = (samp_count_o == '0) ? samp.affine_param6
                                             : affine_param6_o;
   assign comp_data_o = mat_q;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  state_d = ACCUM;
         ACCUM: if (accept) state_d = ROW;
         ROW:   if (row_q == 3'd5) state_d = last_q ? ISSUE : ACCUM;
         ISSUE: state_d = WAIT;
         WAIT:  if (comp_done_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      samp.samp_ready = 1'b0;
      comp_init_o     = 1'b0;
      unique case (state_q)
         ACCUM:   samp.samp_ready = 1'b1;
         ISSUE:   comp_init_o     = 1'b1;
         default: ;
      endcase
   end

   // one row per cycle: c_r times every operand, column 6 is the residual
   always_comb begin
      for (int j = 0; j < 7; j++) begin
         mul_a[j]  = PW'($signed(opnd_q[row_q]));
         mul_b[j]  = PW'($signed(opnd_q[j]));
         prod[j]   = mul_a[j] * mul_b[j];
         addend[j] = W'(prod[j]);
         acc[j]    = $signed(mat_q[row_q][j]);
         sum[j]    = acc[j] + addend[j];
`ifdef AME_EQUATION_BUILDER_SATURATE_EN
         ovf[j] = (acc[j][W-1] == addend[j][W-1]) &&
                  (sum[j][W-1] != acc[j][W-1]);
         if (sat_q[row_q][j])
            row_d[j] = mat_q[row_q][j];
         else if (ovf[j])
            row_d[j] = acc[j][W-1] ? {1'b1, {(W-1){1'b0}}}
                                   : {1'b0, {(W-1){1'b1}}};
         else
            row_d[j] = sum[j];
`else
         row_d[j] = sum[j];
`endif
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         mat_q           <= '0;
         opnd_q          <= '0;
         row_q           <= '0;
         last_q          <= 1'b0;
         affine_param6_o <= 1'b0;
         samp_count_o    <= '0;
      end else if (clr) begin
         mat_q        <= '0;
         row_q        <= '0;
         samp_count_o <= '0;
      end else if (accept) begin
         opnd_q[6]       <= samp.samp_resid;
         opnd_q[5:2]     <= samp.samp_coef[5:2];
         // 4-param blocks zero c0/c1 so rows and columns 0,1 stay clear
         opnd_q[1:0]     <= model6 ? samp.samp_coef[1:0]
                                   : {(2*COEF_BITS){1'b0}};
         last_q          <= samp.samp_last;
         row_q           <= model6 ? 3'd0 : 3'd2;
         affine_param6_o <= model6;
         if (~&samp_count_o)
            samp_count_o <= samp_count_o + SAMP_CNT_BITS'(1);
      end else if (state_q == ROW) begin
         mat_q[row_q] <= row_d;
         row_q        <= row_q + 3'd1;
      end
   end

`ifdef AME_EQUATION_BUILDER_SATURATE_EN
   always_ff @(posedge clk_i) begin
      if (!rst_n_i || clr)
         sat_q <= '0;
      else if (state_q == ROW)
         sat_q[row_q] <= sat_q[row_q] | ovf;
   end
`endif
endmodule
